// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath/ALU.
// Latency: none, plain wires.
// Backpressure: mem_ready from memory stalls the sequencer in fetch/load/store states.
//   master: the control FSM. It reads instr, alu_result0 and mem_ready, and drives every select and enable.
//   slave : the datapath side. It drives instr, alu_result0 and mem_ready, and consumes the controls.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        alu_result0;
    logic        mem_ready;
    logic [4:0]  alu_func;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  result_src;
    logic [2:0]  imm_src;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic        mem_write;
    logic        illegal_instr;
    logic [3:0]  state;

    modport master (
        input  instr, alu_result0, mem_ready,
        output alu_func, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, illegal_instr, state
    );

    modport slave (
        output instr, alu_result0, mem_ready,
        input  alu_func, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_write, reg_write, mem_write, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I+Zbb(count) core: fetch/decode/execute/mem/writeback.
// Latency: 3-5 cycles per instruction, plus one cycle per mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE.
// Backpressure: holds FETCH, MEMREAD and MEMWRITE with stable outputs until mem_ready.
// Ports: clk and rst (synchronous, active high); bus (master) carries instr, alu_result0 and mem_ready in,
//        and ALU op, operand/result/immediate/address selects, write enables, illegal pulse and debug state out.
module multicycle_ctrl (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,  DECODE = 4'd1, MEMADR = 4'd2,  MEMREAD  = 4'd3,
        MEMWB    = 4'd4,  MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I   = 4'd7,
        ALUWB    = 4'd8,  BRANCH = 4'd9, JAL    = 4'd10, JALR_ADR = 4'd11,
        LUI      = 4'd12
    } state_t;

    localparam logic [4:0] OP_AND = 5'd0,  OP_OR  = 5'd1,  OP_XOR = 5'd2,  OP_ADD  = 5'd3,
                           OP_SUB = 5'd4,  OP_SLT = 5'd5,  OP_LTU = 5'd6,  OP_GEU  = 5'd7,
                           OP_GE  = 5'd8,  OP_EQ  = 5'd9,  OP_NE  = 5'd10, OP_SRL  = 5'd11,
                           OP_SRA = 5'd12, OP_SLL = 5'd13, OP_PC4 = 5'd14, OP_PASS = 5'd15,
                           OP_CLZ = 5'd16, OP_CTZ = 5'd17, OP_CPOP = 5'd18;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_OP  = 7'b0110011,
                           OPC_OPIMM = 7'b0010011, OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;

    // State-decoded outputs. They are registered alongside the state so they come straight off flops.
    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       reg_write;
        logic       mem_write;
        logic       pc_jump;
    } moore_t;

    function automatic moore_t moore_of(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH:    begin m.src_b = 2'b10; m.result_src = 2'b10; end
            DECODE:   begin m.src_a = 2'b01; m.src_b = 2'b01; end
            MEMADR:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
            MEMREAD:  m.adr_src = 1'b1;
            MEMWB:    begin m.result_src = 2'b01; m.reg_write = 1'b1; end
            MEMWRITE: begin m.adr_src = 1'b1; m.mem_write = 1'b1; end
            EXEC_R:   m.src_a = 2'b10;
            EXEC_I:   begin m.src_a = 2'b10; m.src_b = 2'b01; end
            ALUWB:    m.reg_write = 1'b1;
            BRANCH:   m.src_a = 2'b10;
            JAL:      begin m.src_a = 2'b01; m.pc_jump = 1'b1; end
            JALR_ADR: begin m.src_a = 2'b10; m.src_b = 2'b01; end
            LUI:      m.src_b = 2'b01;
            default:  m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [4:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_LTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic       unused_instr_bits;
    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign rs2    = bus.instr[24:20];
    assign unused_instr_bits = ^bus.instr[19:15] ^ ^bus.instr[11:7];

    state_t     state_q, state_d, dec_next;
    moore_t     mo_q;
    logic [4:0] exec_op;
    logic       dec_illegal;

    // Instruction decode. The IR is stable from DECODE to the end of the instruction,
    // so exec_op can also drive alu_func in the EXEC and BRANCH states.
    always_comb begin
        exec_op     = OP_ADD;
        dec_illegal = 1'b0;
        dec_next    = FETCH;
        case (opcode)
            OPC_LOAD, OPC_STORE: dec_next = MEMADR;
            OPC_OP: begin
                dec_next = EXEC_R;
                if (funct7 == 7'b0000000)                          exec_op = f3_op(funct3);
                else if (funct7 == 7'b0100000 && funct3 == 3'b000) exec_op = OP_SUB;
                else if (funct7 == 7'b0100000 && funct3 == 3'b101) exec_op = OP_SRA;
                else                                               dec_illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_next = EXEC_I;
                exec_op  = f3_op(funct3);
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0110000) begin
                        // Zbb unary counts share the SLLI encoding space; rs2 picks the op.
                        case (rs2)
                            5'd0:    exec_op = OP_CLZ;
                            5'd1:    exec_op = OP_CTZ;
                            5'd2:    exec_op = OP_CPOP;
                            default: dec_illegal = 1'b1;
                        endcase
                    end else if (funct7 != 7'b0000000) begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000)      exec_op = OP_SRA;
                    else if (funct7 != 7'b0000000) dec_illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                dec_next = BRANCH;
                case (funct3)
                    3'b000:  exec_op = OP_EQ;
                    3'b001:  exec_op = OP_NE;
                    3'b100:  exec_op = OP_SLT;
                    3'b101:  exec_op = OP_GE;
                    3'b110:  exec_op = OP_LTU;
                    3'b111:  exec_op = OP_GEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_JAL:   dec_next = JAL;
            OPC_JALR:  dec_next = JALR_ADR;
            OPC_LUI:   dec_next = LUI;
            OPC_AUIPC: dec_next = ALUWB;   // DECODE already placed PC+imm in ALUOut
            default:   dec_illegal = 1'b1;
        endcase
        if (dec_illegal) dec_next = FETCH;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (bus.mem_ready) state_d = DECODE;
            DECODE:   state_d = dec_next;
            MEMADR:   state_d = (opcode == OPC_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWRITE: if (bus.mem_ready) state_d = FETCH;
            EXEC_R, EXEC_I, LUI, JAL: state_d = ALUWB;
            JALR_ADR: state_d = JAL;
            default:  state_d = FETCH;   // MEMWB, ALUWB, BRANCH
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            mo_q    <= moore_of(FETCH);
        end else begin
            state_q <= state_d;
            mo_q    <= moore_of(state_d);
        end
    end

    always_comb begin
        case (opcode)
            OPC_STORE:          bus.imm_src = 3'b001;
            OPC_BRANCH:         bus.imm_src = 3'b010;
            OPC_JAL:            bus.imm_src = 3'b011;
            OPC_LUI, OPC_AUIPC: bus.imm_src = 3'b100;
            default:            bus.imm_src = 3'b000;
        endcase
    end

    always_comb begin
        case (state_q)
            EXEC_R, EXEC_I, BRANCH: bus.alu_func = exec_op;
            JAL:                    bus.alu_func = OP_PC4;
            LUI:                    bus.alu_func = OP_PASS;
            default:                bus.alu_func = OP_ADD;
        endcase
    end

    assign bus.alu_src_a  = mo_q.src_a;
    assign bus.alu_src_b  = mo_q.src_b;
    assign bus.result_src = mo_q.result_src;
    assign bus.adr_src    = mo_q.adr_src;
    assign bus.state      = state_q;

    // Enables are masked by rst so that an aborted instruction cannot write on the reset cycle.
    assign bus.ir_write      = !rst && (state_q == FETCH) && bus.mem_ready;
    assign bus.pc_write      = !rst && (((state_q == FETCH) && bus.mem_ready) ||
                                        ((state_q == BRANCH) && bus.alu_result0) || mo_q.pc_jump);
    assign bus.reg_write     = !rst && mo_q.reg_write;
    assign bus.mem_write     = !rst && mo_q.mem_write;
    assign bus.illegal_instr = !rst && (state_q == DECODE) && dec_illegal;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level reference model plus directed and random stimulus.
// Latency: n/a.
// Backpressure: random mem_ready stalls in FETCH/MEMREAD/MEMWRITE.
module tb_multicycle_ctrl;
    // State numbering follows the order in which the states are listed for the block.
    localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5, ST_ER = 6,
                   ST_EI = 7, ST_WB = 8, ST_BR = 9, ST_JAL = 10, ST_JA = 11, ST_LUI = 12;
    localparam logic [4:0] F_AND = 5'd0, F_OR = 5'd1, F_XOR = 5'd2, F_ADD = 5'd3, F_SUB = 5'd4,
                           F_SLT = 5'd5, F_LTU = 5'd6, F_GEU = 5'd7, F_GE = 5'd8, F_EQ = 5'd9,
                           F_NE = 5'd10, F_SRL = 5'd11, F_SRA = 5'd12, F_SLL = 5'd13,
                           F_PC4 = 5'd14, F_PASS = 5'd15, F_CLZ = 5'd16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int n_ir = 0, n_pc = 0, n_rw = 0, n_mw = 0, n_cyc = 0;

    // Reference model of the current instruction.
    int         path [8];
    int         plen;
    bit         m_ill, m_wr, m_jump, m_branch, m_store;
    logic [4:0] m_op;
    int         m_imm;   // expected imm_src in DECODE, -1 when the format has no immediate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_path(input int n, input int a, input int b, input int c, input int d, input int e);
        plen = n;
        path[0] = a; path[1] = b; path[2] = c; path[3] = d; path[4] = e;
    endtask

    function automatic logic [4:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'd0: return F_ADD;  3'd1: return F_SLL; 3'd2: return F_SLT; 3'd3: return F_LTU;
            3'd4: return F_XOR;  3'd5: return F_SRL; 3'd6: return F_OR;  default: return F_AND;
        endcase
    endfunction

    task automatic model(input logic [31:0] ins);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] sh;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; sh = ins[24:20];
        m_ill = 1'b0; m_wr = 1'b1; m_jump = 1'b0; m_branch = 1'b0; m_store = 1'b0;
        m_op = F_ADD; m_imm = -1;
        case (opc)
            7'b0000011: begin set_path(5, ST_F, ST_D, ST_MA, ST_MR, ST_MWB); m_imm = 0; end
            7'b0100011: begin set_path(4, ST_F, ST_D, ST_MA, ST_MW, 0); m_wr = 1'b0; m_store = 1'b1; m_imm = 1; end
            7'b0110011: begin
                set_path(4, ST_F, ST_D, ST_ER, ST_WB, 0);
                if (f7 == 7'b0000000)                 m_op = arith_op(f3);
                else if (f7 == 7'b0100000 && f3 == 0) m_op = F_SUB;
                else if (f7 == 7'b0100000 && f3 == 5) m_op = F_SRA;
                else                                  m_ill = 1'b1;
            end
            7'b0010011: begin
                set_path(4, ST_F, ST_D, ST_EI, ST_WB, 0);
                m_imm = 0;
                m_op = arith_op(f3);
                if (f3 == 3'd1 && f7 != 7'b0000000) begin
                    if (f7 == 7'b0110000 && sh <= 5'd2) m_op = F_CLZ + sh;   // CLZ, CTZ, CPOP in order
                    else m_ill = 1'b1;
                end else if (f3 == 3'd5 && f7 != 7'b0000000) begin
                    if (f7 == 7'b0100000) m_op = F_SRA;
                    else m_ill = 1'b1;
                end
            end
            7'b1100011: begin
                set_path(3, ST_F, ST_D, ST_BR, 0, 0);
                m_wr = 1'b0; m_branch = 1'b1; m_imm = 2;
                case (f3)
                    3'd0: m_op = F_EQ;  3'd1: m_op = F_NE;  3'd4: m_op = F_SLT;
                    3'd5: m_op = F_GE;  3'd6: m_op = F_LTU; 3'd7: m_op = F_GEU;
                    default: m_ill = 1'b1;
                endcase
            end
            7'b1101111: begin set_path(4, ST_F, ST_D, ST_JAL, ST_WB, 0); m_jump = 1'b1; m_imm = 3; end
            7'b1100111: begin set_path(5, ST_F, ST_D, ST_JA, ST_JAL, ST_WB); m_jump = 1'b1; m_imm = 0; end
            7'b0110111: begin set_path(4, ST_F, ST_D, ST_LUI, ST_WB, 0); m_imm = 4; end
            7'b0010111: begin set_path(3, ST_F, ST_D, ST_WB, 0, 0); m_imm = 4; end
            default:    m_ill = 1'b1;
        endcase
        if (m_ill) begin
            set_path(2, ST_F, ST_D, 0, 0, 0);
            m_wr = 1'b0; m_jump = 1'b0; m_branch = 1'b0; m_store = 1'b0;
        end
    endtask

    // Drive one cycle (called just after a rising edge) and check outputs on the falling edge.
    task automatic cycle(input int st, input bit mr, input bit ar0, input bit r);
        bit en;
        rst = r; bus.mem_ready = mr; bus.alu_result0 = ar0;
        en = !r;
        @(negedge clk);
        n_cyc++;
        n_ir += int'(bus.ir_write); n_pc += int'(bus.pc_write);
        n_rw += int'(bus.reg_write); n_mw += int'(bus.mem_write);
        chk("state", bus.state, st);
        chk("ir_write", bus.ir_write, en && st == ST_F && mr);
        chk("pc_write", bus.pc_write, en && ((st == ST_F && mr) || (st == ST_BR && ar0) || st == ST_JAL));
        chk("reg_write", bus.reg_write, en && (st == ST_MWB || st == ST_WB));
        chk("mem_write", bus.mem_write, en && st == ST_MW);
        chk("illegal_instr", bus.illegal_instr, en && st == ST_D && m_ill);
        case (st)
            ST_F:   begin chk("adr_src", bus.adr_src, 0); chk("src_a", bus.alu_src_a, 0);
                          chk("src_b", bus.alu_src_b, 2); chk("result_src", bus.result_src, 2);
                          chk("alu_func", bus.alu_func, F_ADD); end
            ST_D:   begin chk("src_a", bus.alu_src_a, 1); chk("src_b", bus.alu_src_b, 1);
                          chk("alu_func", bus.alu_func, F_ADD);
                          if (m_imm >= 0) chk("imm_src", bus.imm_src, m_imm); end
            ST_MA:  begin chk("src_a", bus.alu_src_a, 2); chk("src_b", bus.alu_src_b, 1);
                          chk("imm_src", bus.imm_src, m_store ? 1 : 0); chk("alu_func", bus.alu_func, F_ADD); end
            ST_MR, ST_MW: begin chk("adr_src", bus.adr_src, 1); chk("result_src", bus.result_src, 0); end
            ST_MWB: chk("result_src", bus.result_src, 1);
            ST_ER:  begin chk("src_a", bus.alu_src_a, 2); chk("src_b", bus.alu_src_b, 0);
                          chk("alu_func", bus.alu_func, m_op); end
            ST_EI:  begin chk("src_a", bus.alu_src_a, 2); chk("src_b", bus.alu_src_b, 1);
                          chk("imm_src", bus.imm_src, 0); chk("alu_func", bus.alu_func, m_op); end
            ST_WB:  chk("result_src", bus.result_src, 0);
            ST_BR:  begin chk("src_a", bus.alu_src_a, 2); chk("src_b", bus.alu_src_b, 0);
                          chk("result_src", bus.result_src, 0); chk("alu_func", bus.alu_func, m_op); end
            ST_JAL: begin chk("src_a", bus.alu_src_a, 1); chk("result_src", bus.result_src, 0);
                          chk("alu_func", bus.alu_func, F_PC4); end
            ST_JA:  begin chk("src_a", bus.alu_src_a, 2); chk("src_b", bus.alu_src_b, 1);
                          chk("imm_src", bus.imm_src, 0); chk("alu_func", bus.alu_func, F_ADD); end
            ST_LUI: begin chk("src_b", bus.alu_src_b, 1); chk("imm_src", bus.imm_src, 4);
                          chk("alu_func", bus.alu_func, F_PASS); end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Run one instruction. taken<0 picks the branch outcome randomly; abort_at>=0 asserts rst
    // on the first cycle of that step and abandons the instruction.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input int taken, input int abort_at);
        int i0, p0, r0, w0;
        bit tk;
        i0 = n_ir; p0 = n_pc; r0 = n_rw; w0 = n_mw;
        model(ins);
        tk = (taken < 0) ? bit'($urandom_range(0, 1)) : (taken != 0);
        for (int s = 0; s < plen; s++) begin
            int  st;
            int  waits;
            bit  stall_state;
            st = path[s];
            stall_state = (st == ST_F || st == ST_MR || st == ST_MW);
            waits = (st == ST_F) ? fw : (stall_state ? mw : 0);
            if (st == ST_D) bus.instr = ins;
            if (s == abort_at) begin
                cycle(st, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1);
                return;
            end
            for (int w = 0; w < waits; w++) cycle(st, 1'b0, bit'($urandom_range(0, 1)), 1'b0);
            cycle(st, stall_state ? 1'b1 : bit'($urandom_range(0, 1)),
                  (st == ST_BR) ? tk : bit'($urandom_range(0, 1)), 1'b0);
        end
        chk("ir_pulses", n_ir - i0, 1);
        chk("pc_pulses", n_pc - p0, 1 + int'(m_jump) + int'(m_branch && tk));
        chk("reg_pulses", n_rw - r0, int'(m_wr));
        chk("mem_write_cycles", n_mw - w0, m_store ? mw + 1 : 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:       r[6:0] = 7'b0000011;
            1:       r[6:0] = 7'b0100011;
            2, 3:    r[6:0] = 7'b0110011;
            4, 5:    r[6:0] = 7'b0010011;
            6:       r[6:0] = 7'b1100011;
            7:       r[6:0] = 7'b1101111;
            8:       r[6:0] = 7'b1100111;
            9:       r[6:0] = 7'b0110111;
            10:      r[6:0] = 7'b0010111;
            default: r[6:0] = r[6:0];
        endcase
        case ($urandom_range(0, 3))
            0:       r[31:25] = 7'b0000000;
            1:       r[31:25] = 7'b0100000;
            2:       r[31:25] = 7'b0110000;
            default: r[31:25] = r[31:25];
        endcase
        if ($urandom_range(0, 1) == 1) r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin
        int c0;
        bus.instr = 32'h0000_0013;
        bus.mem_ready = 1'b1;
        bus.alu_result0 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        model(32'h0000_0013);
        // Reset holds FETCH with every enable forced low even though mem_ready is high.
        cycle(ST_F, 1'b1, 1'b1, 1'b1);
        cycle(ST_F, 1'b1, 1'b0, 1'b1);

        // ADD x3,x1,x2
        model(32'h0020_81B3);
        chk("pin_add_op", m_op, 5'b00011);
        chk("pin_add_len", plen, 4);
        run_instr(32'h0020_81B3, 0, 0, -1, -1);

        // LW x5,0(x1) with two fetch stalls and one read stall
        c0 = n_cyc;
        run_instr(32'h0000_A283, 2, 1, -1, -1);
        chk("lw_cycles", n_cyc - c0, 8);

        // BNE x1,x2 taken and not taken
        model(32'h0020_9063);
        chk("pin_bne_op", m_op, 5'b01010);
        run_instr(32'h0020_9063, 0, 0, 1, -1);
        run_instr(32'h0020_9063, 1, 0, 0, -1);

        // CPOP and the unsupported neighbouring rs2 encoding
        model(32'h6020_9093);
        chk("pin_cpop_op", m_op, 5'b10010);
        run_instr(32'h6020_9093, 0, 0, -1, -1);
        model(32'h6030_9093);
        chk("pin_zbb_bad", m_ill, 1);
        run_instr(32'h6030_9093, 0, 0, -1, -1);

        // JALR x1,0(x1)
        model(32'h0000_80E7);
        chk("pin_jalr_len", plen, 5);
        run_instr(32'h0000_80E7, 0, 0, -1, -1);

        // SW x2,0(x1): reset while MEMWRITE is stalled
        model(32'h0020_A023);
        cycle(ST_F, 1'b1, 1'b0, 1'b0);
        bus.instr = 32'h0020_A023;
        cycle(ST_D, 1'b0, 1'b0, 1'b0);
        cycle(ST_MA, 1'b0, 1'b0, 1'b0);
        cycle(ST_MW, 1'b0, 1'b0, 1'b0);
        cycle(ST_MW, 1'b0, 1'b0, 1'b1);
        cycle(ST_F, 1'b0, 1'b0, 1'b0);

        // Random instruction stream with stalls and occasional mid-instruction resets
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            int ab;
            ins = rand_instr();
            model(ins);
            ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, plen - 1) : -1;
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2), -1, ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multicycle RV32I+Zbb(count) core, sitting directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback. Every cycle it drives the ALU operation code, operand selects, register/memory/PC write enables and immediate type. It closes the branch loop by consuming bit 0 of the ALU result.

## Interface
- No parameters.
- clk  in  1  single core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction register contents (valid from DECODE onward).
- alu_result0  in  1  bit 0 of ALU output (branch comparison result).
- mem_ready  in  1  memory completes the current access this cycle.
- alu_func  out  5  ALU op code.
  - 00000 AND, 00001 OR, 00010 XOR, 00011 ADD, 00100 SUB.
  - 00101 SLT, 00110 LTU, 00111 GEU, 01000 GE, 01001 EQ, 01010 NE.
  - 01011 SRL, 01100 SRA, 01101 SLL.
  - 01110 src1+4, 01111 pass src2.
  - 10000 CLZ, 10001 CTZ, 10010 CPOP.
- alu_src_a  out  2  00 PC, 01 old PC, 10 register A.
- alu_src_b  out  2  00 register B, 01 immediate, 10 constant 4.
- result_src  out  2  00 ALUOut register, 01 memory data register, 10 live ALU output.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- adr_src  out  1  memory address: 0 PC, 1 result bus.
- ir_write, pc_write, reg_write, mem_write  out  1 each  write enables.
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction.
- state  out  4  current state encoding (debug).

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, LUI.
- Outputs are Moore (state-decoded), except for these exceptions:
  - alu_func depends on instr fields.
  - pc_write in BRANCH equals alu_result0.
  - pc_write/ir_write in FETCH are gated by mem_ready.
- Unlisted selects are don't-care; unlisted enables are 0.
- FETCH:
  - adr_src=0, src_a=PC, src_b=4, ADD, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - src_a=old PC, src_b=imm, ADD (branch/jump/AUIPC target into ALUOut).
  - imm_src set from opcode.
  - Next state by opcode:
    - 0000011/0100011 → MEMADR.
    - 0110011 → EXEC_R.
    - 0010011 → EXEC_I.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - 1100111 → JALR_ADR.
    - 0110111 → LUI.
    - 0010111 → ALUWB.
    - Any other opcode → FETCH with illegal_instr=1.
- MEMADR: src_a=A, src_b=imm, ADD. Next MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held until mem_ready. Next FETCH.
- EXEC_R (A,B) and EXEC_I (A,imm) select the op by funct3:
  - 000: ADD, or SUB when R and instr[30]=1.
  - 001: SLL. 010: SLT. 011: LTU. 100: XOR.
  - 101: SRL, or SRA when instr[30]=1.
  - 110: OR. 111: AND.
  - Then go to ALUWB.
- Zbb counts in EXEC_I: funct3=001 with instr[31:25]=0110000 selects by instr[24:20]:
  - 00000 → CLZ, 00001 → CTZ, 00010 → CPOP.
  - Any other rs2 value → illegal.
- Illegal funct encodings (R funct7 other than 0000000/0100000, SUB/SRA bit on non-ADD/SRL ops, unsupported Zbb fields):
  - Detected in DECODE; illegal_instr pulses and the next state is FETCH.
  - No write enable is asserted.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH:
  - src_a=A, src_b=B, result_src=00, pc_write=alu_result0. Next FETCH.
  - funct3 to op: 000 EQ, 001 NE, 100 SLT, 101 GE, 110 LTU, 111 GEU.
  - funct3 010/011 is illegal (detected in DECODE).
- JAL:
  - src_a=old PC, op=src1+4 (link value into ALUOut).
  - result_src=00, pc_write=1 (target taken from ALUOut). Next ALUWB.
- JALR_ADR: src_a=A, src_b=imm (I), ADD. Next JAL.
- LUI: src_b=imm (U), op=pass src2. Next ALUWB.

## Timing
- rst high at a clock edge: state ← FETCH. While rst is high, all write enables and illegal_instr are forced to 0.
- rst mid-instruction aborts the instruction. No partial write is issued after the reset edge.
- CPI with mem_ready asserted on its first requested cycle:
  - 3 cycles: branch, AUIPC.
  - 4 cycles: R, I, SW, JAL, LUI.
  - 5 cycles: LW, JALR.
- Each extra mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable during the wait.
- Exactly one reg_write pulse per writing instruction. None for branch, store or illegal instructions.
- Exactly one pc_write in FETCH per instruction, plus at most one in BRANCH or JAL.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready=1:
  - Required states: FETCH, DECODE, EXEC_R, ALUWB.
  - alu_func=00011 in EXEC_R; reg_write only in ALUWB.
- LW with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMREAD:
  - Total 8 cycles.
  - ir_write fires once; reg_write fires once, in MEMWB with result_src=01.
- BNE funct3=001:
  - alu_result0=1 → pc_write=1 in BRANCH.
  - alu_result0=0 → pc_write=0.
  - alu_func=01010 in both cases.
- CPOP (0x60209093 pattern, rs2=00010) → alu_func=10010 in EXEC_I.
  - With rs2=00011 → illegal_instr pulse in DECODE, no reg_write, next FETCH.
- JALR:
  - Required states: DECODE, JALR_ADR (ADD), JAL (func 01110, pc_write=1), ALUWB (reg_write=1).
- rst asserted during MEMWRITE while mem_ready=0:
  - Next cycle state=FETCH.
  - mem_write=0 in the reset cycle and afterwards.
